// File: rtl/uart_rx_if.sv
// Signal bundle between a serial receiver and its consumer: the line and lock
// inputs plus the received byte and status strobes.
interface uart_rx_if #(
    parameter int DATAWIDTH_BUS = 8
) ();
    logic                     UART_RX_rx_In;
    logic                     UART_RX_LOCK_InHigh;
    logic [DATAWIDTH_BUS-1:0] UART_RX_data_Out;
    logic                     UART_RX_newData_Out;
    logic                     UART_RX_frameError_Out;
    logic                     UART_RX_busy_Out;

    modport slave (
        input  UART_RX_rx_In,
        input  UART_RX_LOCK_InHigh,
        output UART_RX_data_Out,
        output UART_RX_newData_Out,
        output UART_RX_frameError_Out,
        output UART_RX_busy_Out
    );

    modport master (
        output UART_RX_rx_In,
        output UART_RX_LOCK_InHigh,
        input  UART_RX_data_Out,
        input  UART_RX_newData_Out,
        input  UART_RX_frameError_Out,
        input  UART_RX_busy_Out
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling of a synchronized line, one stop
// bit checked, one-cycle strobes for a good byte or a framing error.
module uart_rx #(
    parameter int CLOCK_PER_BIT = 434,
    parameter int DATAWIDTH_BUS = 8,
    parameter int STATE_SIZE    = 3
) (
    input  logic     UART_RX_CLOCK_50,
    input  logic     UART_RX_RESET_InLow,
    uart_rx_if.slave bus
);
    localparam int CNT_W = $clog2(CLOCK_PER_BIT);
    localparam int IDX_W = $clog2(DATAWIDTH_BUS);

    localparam logic [STATE_SIZE-1:0] S_IDLE      = STATE_SIZE'(3'd0);
    localparam logic [STATE_SIZE-1:0] S_START     = STATE_SIZE'(3'd1);
    localparam logic [STATE_SIZE-1:0] S_DATA      = STATE_SIZE'(3'd2);
    localparam logic [STATE_SIZE-1:0] S_STOP      = STATE_SIZE'(3'd3);
    localparam logic [STATE_SIZE-1:0] S_DONE      = STATE_SIZE'(3'd4);
    localparam logic [STATE_SIZE-1:0] S_WAIT_IDLE = STATE_SIZE'(3'd5);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLOCK_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLOCK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATAWIDTH_BUS - 1);

    logic                     r_rx_meta;
    logic                     r_rxs;
    logic [STATE_SIZE-1:0]    r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic [DATAWIDTH_BUS-1:0] r_shift;
    logic [DATAWIDTH_BUS-1:0] r_data;
    logic                     r_new;
    logic                     r_ferr;
    logic                     r_busy;

    logic [STATE_SIZE-1:0]    w_state_next;
    logic                     w_hit;
    logic                     w_stop_ok;
    logic                     w_stop_bad;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge UART_RX_CLOCK_50 or negedge UART_RX_RESET_InLow) begin
        if (!UART_RX_RESET_InLow) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= bus.UART_RX_rx_In;
            r_rxs     <= r_rx_meta;
        end
    end

    // Next-state logic; w_hit marks the cycle the current bit is sampled.
    always_comb begin
        w_state_next = r_state;
        w_hit        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxs && !bus.UART_RX_LOCK_InHigh) begin
                    w_state_next = S_START;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                w_hit = (r_cnt == HALF_CNT);
                if (w_hit) begin
                    w_state_next = r_rxs ? S_IDLE : S_DATA;
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                w_hit = (r_cnt == LAST_CNT);
                if (w_hit && (r_idx == LAST_IDX)) begin
                    w_state_next = S_STOP;
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_STOP: begin
                w_hit = (r_cnt == LAST_CNT);
                if (w_hit) begin
                    w_state_next = r_rxs ? S_DONE : S_WAIT_IDLE;
                end else begin
                    w_state_next = S_STOP;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            S_WAIT_IDLE: begin
                if (r_rxs) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_WAIT_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_stop_ok  = (r_state == S_STOP) && w_hit && r_rxs;
    assign w_stop_bad = (r_state == S_STOP) && w_hit && !r_rxs;

    // State, bit timing, bit index and shift register.
    always_ff @(posedge UART_RX_CLOCK_50 or negedge UART_RX_RESET_InLow) begin
        if (!UART_RX_RESET_InLow) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next != r_state) || w_hit || (r_state == S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1'b1);
            end
            if (r_state != S_DATA) begin
                r_idx <= '0;
            end else if (w_hit) begin
                r_idx <= r_idx + IDX_W'(1'b1);
            end else begin
                r_idx <= r_idx;
            end
            if ((r_state == S_DATA) && w_hit) begin
                r_shift <= {r_rxs, r_shift[DATAWIDTH_BUS-1:1]};
            end else begin
                r_shift <= r_shift;
            end
        end
    end

    // Registered outputs; strobes are raised as the FSM enters DONE or WAIT_IDLE.
    always_ff @(posedge UART_RX_CLOCK_50 or negedge UART_RX_RESET_InLow) begin
        if (!UART_RX_RESET_InLow) begin
            r_data <= '0;
            r_new  <= 1'b0;
            r_ferr <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_new  <= w_stop_ok;
            r_ferr <= w_stop_bad;
            r_busy <= (w_state_next != S_IDLE);
            if (w_stop_ok) begin
                r_data <= r_shift;
            end else begin
                r_data <= r_data;
            end
        end
    end

    assign bus.UART_RX_data_Out       = r_data;
    assign bus.UART_RX_newData_Out    = r_new;
    assign bus.UART_RX_frameError_Out = r_ferr;
    assign bus.UART_RX_busy_Out       = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialized at 434 clk/bit and the
// expected byte or framing error is queued, then matched against the strobes.
module tb_uart_rx;
    localparam int CPB = 434;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_new    = 0;
    int   n_ferr   = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_if #(.DATAWIDTH_BUS(8)) u_if ();

    uart_rx u_dut (
        .UART_RX_CLOCK_50    (clk),
        .UART_RX_RESET_InLow (rst_n),
        .bus                 (u_if)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Serialize start, 8 data bits LSB first and one stop bit; raise lock at bit lock_bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int lock_bit);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            if (b == lock_bit) u_if.UART_RX_LOCK_InHigh = 1'b1;
            u_if.UART_RX_rx_In = bits[b];
            idle(CPB);
        end
    endtask

    task automatic push(input logic err, input logic [7:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        q.push_back(e);
    endtask

    // Strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (u_if.UART_RX_newData_Out || u_if.UART_RX_frameError_Out) begin
            chk("strobe_excl", {31'd0, u_if.UART_RX_newData_Out & u_if.UART_RX_frameError_Out}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                if (u_if.UART_RX_newData_Out) begin
                    n_new++;
                    chk("new_kind", 32'd0, {31'd0, e.err});
                    chk("data", {24'd0, u_if.UART_RX_data_Out}, {24'd0, e.data});
                    last_good = e.data;
                end else begin
                    n_ferr++;
                    chk("ferr_kind", 32'd1, {31'd0, e.err});
                    chk("ferr_hold", {24'd0, u_if.UART_RX_data_Out}, {24'd0, last_good});
                end
            end
        end
    end

    initial begin
        int k;
        u_if.UART_RX_rx_In       = 1'b1;
        u_if.UART_RX_LOCK_InHigh = 1'b0;
        idle(5);
        #1;
        chk("rst_data", {24'd0, u_if.UART_RX_data_Out}, 32'd0);
        chk("rst_new",  {31'd0, u_if.UART_RX_newData_Out}, 32'd0);
        chk("rst_ferr", {31'd0, u_if.UART_RX_frameError_Out}, 32'd0);
        chk("rst_busy", {31'd0, u_if.UART_RX_busy_Out}, 32'd0);
        rst_n = 1'b1;
        idle(20);

        // Nominal frame.
        push(1'b0, 8'hA5);
        send_frame(8'hA5, 1'b1, -1);
        chk("a5_count", n_new, 1);
        chk("a5_busy", {31'd0, u_if.UART_RX_busy_Out}, 32'd0);
        idle(50);

        // Short low glitch on an idle line.
        k = n_new + n_ferr;
        u_if.UART_RX_rx_In = 1'b0;
        idle(100);
        u_if.UART_RX_rx_In = 1'b1;
        idle(50);
        chk("glitch_busy_mid", {31'd0, u_if.UART_RX_busy_Out}, 32'd1);
        idle(250);
        chk("glitch_busy", {31'd0, u_if.UART_RX_busy_Out}, 32'd0);
        chk("glitch_pulses", n_new + n_ferr, k);
        chk("glitch_data", {24'd0, u_if.UART_RX_data_Out}, 32'h0000_00A5);

        // Framing error followed by a long low line.
        push(1'b1, 8'h00);
        send_frame(8'h3C, 1'b0, -1);
        idle(2000);
        chk("ferr_count", n_ferr, 1);
        chk("ferr_busy_low_line", {31'd0, u_if.UART_RX_busy_Out}, 32'd1);
        chk("ferr_data_kept", {24'd0, u_if.UART_RX_data_Out}, 32'h0000_00A5);
        u_if.UART_RX_rx_In = 1'b1;
        idle(10);
        chk("ferr_busy_release", {31'd0, u_if.UART_RX_busy_Out}, 32'd0);
        idle(50);

        // Back-to-back frames with a single stop bit.
        push(1'b0, 8'h00);
        push(1'b0, 8'hFF);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        chk("b2b_count", n_new, 3);
        idle(50);

        // Reset asserted during data bit 4, then the frame is resent.
        u_if.UART_RX_rx_In = 1'b0;
        idle(CPB);
        for (int b = 0; b < 4; b++) begin
            u_if.UART_RX_rx_In = b[0];
            idle(CPB);
        end
        u_if.UART_RX_rx_In = 1'b0;
        idle(200);
        chk("mid_busy", {31'd0, u_if.UART_RX_busy_Out}, 32'd1);
        rst_n = 1'b0;
        last_good = 8'h00;
        #1;
        chk("mid_rst_data", {24'd0, u_if.UART_RX_data_Out}, 32'd0);
        chk("mid_rst_busy", {31'd0, u_if.UART_RX_busy_Out}, 32'd0);
        chk("mid_rst_new", {31'd0, u_if.UART_RX_newData_Out}, 32'd0);
        u_if.UART_RX_rx_In = 1'b1;
        idle(10);
        rst_n = 1'b1;
        idle(300);
        chk("mid_no_pulse", n_new + n_ferr, 4);
        push(1'b0, 8'hC2);
        send_frame(8'hC2, 1'b1, -1);
        chk("resend_count", n_new, 4);
        idle(50);

        // Lock held while a frame starts: ignored.
        u_if.UART_RX_LOCK_InHigh = 1'b1;
        send_frame(8'h5A, 1'b1, -1);
        idle(100);
        u_if.UART_RX_LOCK_InHigh = 1'b0;
        idle(100);
        chk("lock_start_pulses", n_new + n_ferr, 5);
        chk("lock_start_busy", {31'd0, u_if.UART_RX_busy_Out}, 32'd0);
        chk("lock_start_data", {24'd0, u_if.UART_RX_data_Out}, 32'h0000_00C2);

        // Lock raised mid-frame: frame still received.
        push(1'b0, 8'h96);
        send_frame(8'h96, 1'b1, 4);
        u_if.UART_RX_LOCK_InHigh = 1'b0;
        chk("lock_mid_count", n_new, 5);
        idle(50);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
